// File: rtl/bullet_pkg.sv
// Shared screen geometry, colour types and helpers for the bullet pool.
package bullet_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int COORD_W  = 10;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [11:0]        rgb444_t;

   localparam rgb444_t RGB_BLACK  = 12'h000;
   localparam rgb444_t RGB_BULLET = 12'h00F;

   // 11-bit span test so lo+len never wraps at the screen edge
   function automatic logic in_span(input coord_t v,
                                    input coord_t lo,
                                    input int unsigned len);
      logic [COORD_W:0] v_e;
      logic [COORD_W:0] lo_e;
      logic [COORD_W:0] hi_e;
      v_e  = {1'b0, v};
      lo_e = {1'b0, lo};
      hi_e = lo_e + (COORD_W+1)'(len);
      return (v_e >= lo_e) && (v_e < hi_e);
   endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: position state, per-frame move, clear, spawn and the
// combinational pixel-coverage test for the display path.
module bullet_slot
   import bullet_pkg::*;
#(
   parameter int BW    = 4,
   parameter int BH    = 16,
   parameter int SPEED = 2
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   tick,
   input  logic   spawn,
   input  coord_t spawn_x,
   input  coord_t spawn_y,
   input  logic   hit,
   input  coord_t pix_x,
   input  coord_t pix_y,
   output logic   active,
   output coord_t x,
   output coord_t y,
   output logic   pix_hit
);

   localparam coord_t SPD = coord_t'(SPEED);

   // A spawn only targets a free slot, so it outranks any hit on it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active <= 1'b0;
         x      <= '0;
         y      <= '0;
      end else if (spawn) begin
         active <= 1'b1;
         x      <= spawn_x;
         y      <= spawn_y;
      end else if (hit) begin
         active <= 1'b0;
      end else if (tick && active) begin
         if (y < SPD) begin
            active <= 1'b0;
         end else begin
            y <= y - SPD;
         end
      end
   end

   always_comb begin
      pix_hit = active
              && in_span(pix_x, x, BW)
              && in_span(pix_y, y, BH);
   end

endmodule

// File: rtl/bullet_pool.sv
// Player bullet pool: slot array, lowest-free spawn selection, frame
// cooldown and the registered pixel enable/colour for the mixer.
module bullet_pool
   import bullet_pkg::*;
#(
   parameter int      NUM_BULLETS = 4,
   parameter int      BW          = 4,
   parameter int      BH          = 16,
   parameter int      SPEED       = 2,
   parameter int      COOLDOWN    = 8,
   parameter int      MUZZLE_DX   = 23,
   parameter rgb444_t COLOR       = RGB_BULLET
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        frame_tick,
   input  logic                        fire,
   input  logic [9:0]                  p_x,
   input  logic [9:0]                  p_y,
   input  logic                        hit_valid,
   input  logic [3:0]                  hit_idx,
   input  logic [9:0]                  pix_x,
   input  logic [9:0]                  pix_y,
   output logic [NUM_BULLETS-1:0]      active,
   output logic [10*NUM_BULLETS-1:0]   b_x,
   output logic [10*NUM_BULLETS-1:0]   b_y,
   output logic                        fire_ack,
   output logic                        bullet_en,
   output logic [11:0]                 bullet_rgb
);

   logic [7:0]             cooldown;
   logic [NUM_BULLETS-1:0] spawn_sel;
   logic [NUM_BULLETS-1:0] slot_hit;
   logic [NUM_BULLETS-1:0] pix_hit;
   logic                   any_free;
   logic                   can_spawn;
   coord_t                 spawn_x;
   coord_t                 spawn_y;

   assign any_free = ~&active;
   assign spawn_x  = p_x + coord_t'(MUZZLE_DX);
   assign spawn_y  = p_y - coord_t'(BH);

   assign can_spawn = frame_tick && fire && (cooldown == 8'd0)
                   && any_free && (p_y >= coord_t'(BH));

   // Lowest-index free slot, from the mask registered before this cycle.
   always_comb begin
      logic found;
      spawn_sel = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (!active[i] && !found) begin
            spawn_sel[i] = can_spawn;
            found        = 1'b1;
         end
      end
   end

   always_comb begin
      slot_hit = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         slot_hit[i] = hit_valid && (hit_idx == 4'(i));
      end
   end

   for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
      bullet_slot #(
         .BW    (BW),
         .BH    (BH),
         .SPEED (SPEED)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .tick    (frame_tick),
         .spawn   (spawn_sel[i]),
         .spawn_x (spawn_x),
         .spawn_y (spawn_y),
         .hit     (slot_hit[i]),
         .pix_x   (pix_x),
         .pix_y   (pix_y),
         .active  (active[i]),
         .x       (b_x[10*i +: 10]),
         .y       (b_y[10*i +: 10]),
         .pix_hit (pix_hit[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cooldown <= 8'd0;
         fire_ack <= 1'b0;
      end else begin
         fire_ack <= can_spawn;
         if (can_spawn) begin
            cooldown <= 8'(COOLDOWN);
         end else if (frame_tick && cooldown != 8'd0) begin
            cooldown <= cooldown - 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bullet_en  <= 1'b0;
         bullet_rgb <= RGB_BLACK;
      end else begin
         bullet_en  <= |pix_hit;
         bullet_rgb <= (|pix_hit) ? COLOR : RGB_BLACK;
      end
   end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: pixel vector table plus hand-written
// spawn, cooldown, edge-exit, hit and reset sequences.
module tb_bullet_pool;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_tick = 1'b0;
   logic          fire = 1'b0;
   logic [9:0]    p_x = '0;
   logic [9:0]    p_y = '0;
   logic          hit_valid = 1'b0;
   logic [3:0]    hit_idx = '0;
   logic [9:0]    pix_x = '0;
   logic [9:0]    pix_y = '0;
   logic [N-1:0]  active;
   logic [10*N-1:0] b_x;
   logic [10*N-1:0] b_y;
   logic          fire_ack;
   logic          bullet_en;
   logic [11:0]   bullet_rgb;

   int n_cmp = 0;
   int n_bad = 0;

   bullet_pool dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .fire       (fire),
      .p_x        (p_x),
      .p_y        (p_y),
      .hit_valid  (hit_valid),
      .hit_idx    (hit_idx),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .active     (active),
      .b_x        (b_x),
      .b_y        (b_y),
      .fire_ack   (fire_ack),
      .bullet_en  (bullet_en),
      .bullet_rgb (bullet_rgb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  px;
      logic [9:0]  py;
      logic        en;
      logic [11:0] rgb;
   } pix_vec_t;

   pix_vec_t pv[6];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   function automatic logic [9:0] sx(input int i);
      return b_x[10*i +: 10];
   endfunction

   function automatic logic [9:0] sy(input int i);
      return b_y[10*i +: 10];
   endfunction

   // One clock cycle of stimulus; returns at the next negedge.
   task automatic step(input logic t, input logic f,
                       input logic hv, input logic [3:0] hi);
      @(negedge clk);
      frame_tick = t;
      fire       = f;
      hit_valid  = hv;
      hit_idx    = hi;
      @(negedge clk);
      frame_tick = 1'b0;
      fire       = 1'b0;
      hit_valid  = 1'b0;
      hit_idx    = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      pv[0] = '{10'd123, 10'd384, 1'b1, 12'h00F};
      pv[1] = '{10'd126, 10'd399, 1'b1, 12'h00F};
      pv[2] = '{10'd127, 10'd384, 1'b0, 12'h000};
      pv[3] = '{10'd123, 10'd400, 1'b0, 12'h000};
      pv[4] = '{10'd122, 10'd390, 1'b0, 12'h000};
      pv[5] = '{10'd124, 10'd383, 1'b0, 12'h000};

      // Reset state
      do_reset();
      check("rst_active", 32'(active), 0);
      check("rst_bx", 32'(b_x), 0);
      check("rst_by", 32'(b_y), 0);
      check("rst_ack", 32'(fire_ack), 0);
      check("rst_en", 32'(bullet_en), 0);
      check("rst_rgb", 32'(bullet_rgb), 0);

      // First spawn, then cooldown-paced spawns with fire held
      p_x = 10'd100;
      p_y = 10'd400;
      for (int t = 0; t <= 36; t++) begin
         step(1'b1, 1'b1, 1'b0, 4'd0);
         check($sformatf("cd_ack_t%0d", t), 32'(fire_ack),
               32'((t % 9 == 0) && (t < 36)));
         if (t == 0) begin
            check("spawn_active", 32'(active), 1);
            check("spawn_x", 32'(sx(0)), 123);
            check("spawn_y", 32'(sy(0)), 384);
         end
         if (t == 1) begin
            check("move_y", 32'(sy(0)), 382);
            check("ack_once", 32'(fire_ack), 0);
         end
      end
      check("full_active", 32'(active), 32'hF);
      check("full_y3", 32'(sy(3)), 384 - 2 * 9);
      check("full_y0", 32'(sy(0)), 384 - 2 * 36);

      // Top-edge exit and slot reuse
      do_reset();
      step(1'b1, 1'b1, 1'b0, 4'd0);
      for (int t = 1; t < 9; t++) step(1'b1, 1'b0, 1'b0, 4'd0);
      p_y = 10'd17;
      step(1'b1, 1'b1, 1'b0, 4'd0);
      check("edge_spawn_y", 32'(sy(1)), 1);
      check("edge_spawn_act", 32'(active), 3);
      step(1'b1, 1'b0, 1'b0, 4'd0);
      check("edge_exit_act", 32'(active), 1);
      check("edge_freeze_y", 32'(sy(1)), 1);
      for (int t = 0; t < 7; t++) step(1'b1, 1'b0, 1'b0, 4'd0);
      p_x = 10'd200;
      p_y = 10'd300;
      step(1'b1, 1'b1, 1'b0, 4'd0);
      check("reuse_ack", 32'(fire_ack), 1);
      check("reuse_act", 32'(active), 3);
      check("reuse_x", 32'(sx(1)), 223);
      check("reuse_y", 32'(sy(1)), 284);

      // Hit coinciding with a frame tick, then an out-of-range index
      do_reset();
      p_x = 10'd100;
      p_y = 10'd400;
      step(1'b1, 1'b1, 1'b0, 4'd0);
      for (int t = 1; t < 9; t++) step(1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b0, 4'd0);
      check("hit_pre_act", 32'(active), 3);
      step(1'b1, 1'b0, 1'b1, 4'd1);
      check("hit_act", 32'(active), 1);
      check("hit_y0", 32'(sy(0)), 364);
      step(1'b0, 1'b0, 1'b1, 4'd7);
      check("hit7_act", 32'(active), 1);
      check("hit7_y0", 32'(sy(0)), 364);
      step(1'b0, 1'b0, 1'b1, 4'd0);
      check("hit0_act", 32'(active), 0);

      // Pixel coverage table against a bullet at (123,384)
      do_reset();
      step(1'b1, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pix_x = pv[i].px;
         pix_y = pv[i].py;
         @(negedge clk);
         check($sformatf("pix%0d_en", i), 32'(bullet_en), 32'(pv[i].en));
         check($sformatf("pix%0d_rgb", i), 32'(bullet_rgb), 32'(pv[i].rgb));
      end

      // Asynchronous reset mid-frame with three live slots
      do_reset();
      step(1'b1, 1'b1, 1'b0, 4'd0);
      for (int t = 1; t < 9; t++) step(1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b0, 4'd0);
      for (int t = 1; t < 9; t++) step(1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b0, 4'd0);
      check("arst_pre_act", 32'(active), 7);
      @(negedge clk);
      pix_x = 10'd123;
      pix_y = 10'd384;
      @(negedge clk);
      check("arst_pre_en", 32'(bullet_en), 1);
      #2 rst = 1'b1;
      #1;
      check("arst_act", 32'(active), 0);
      check("arst_en", 32'(bullet_en), 0);
      check("arst_rgb", 32'(bullet_rgb), 0);
      @(negedge clk);
      rst = 1'b0;
      p_y = 10'd10;
      step(1'b1, 1'b1, 1'b0, 4'd0);
      check("low_py_ack", 32'(fire_ack), 0);
      check("low_py_act", 32'(active), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bullet_pool.md
# bullet_pool

Parametrised player-bullet manager for the 640x480 VGA shooter. It holds up to `NUM_BULLETS` independent bullet slots and spawns a bullet at the player's muzzle on a fire request, subject to a frame-based cooldown. Each slot moves upward once per frame and frees itself at the top edge or on an external hit. It also produces a registered per-pixel enable/colour for the display mixer. It sits between player control, the collision judge (which reports hits by slot index) and the VGA pixel mixer.

## Interface
Parameters:
- `NUM_BULLETS`, 4: number of slots, 1..16.
- `BW`, 4: bullet width in pixels.
- `BH`, 16: bullet height in pixels.
- `SPEED`, 2: pixels moved up per frame tick, 1..15.
- `COOLDOWN`, 8: frame ticks between accepted shots, 0..255.
- `MUZZLE_DX`, 23: x offset from `p_x` to bullet left edge.
- `COLOR`, 12'h00F: RGB444 bullet colour.

Ports:
- `clk`  in  1  pixel/system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse, once per frame (vblank start).
- `fire`  in  1  level fire request, sampled only on `frame_tick`.
- `p_x`, `p_y`  in  10 each  player sprite top-left, screen coordinates.
- `hit_valid`  in  1  collision judge clears a slot this cycle.
- `hit_idx`  in  4  slot to clear; only values below `NUM_BULLETS` are meaningful.
- `pix_x`, `pix_y`  in  10 each  current scan position.
- `active`  out  NUM_BULLETS  per-slot active mask.
- `b_x`, `b_y`  out  10*NUM_BULLETS each  packed slot positions; slot i occupies bits [10i+9:10i].
- `fire_ack`  out  1  one-cycle pulse on a successful spawn.
- `bullet_en`  out  1  registered: current pixel lies inside an active bullet.
- `bullet_rgb`  out  12  registered: `COLOR` when `bullet_en` is high, else 0.

## Operation
- Slot state: `active` bit, 10-bit x, 10-bit y (top-left corner). The cooldown counter is 8 bits.
- Reset values: every `active` = 0, every x = 0, every y = 0, cooldown = 0, `fire_ack` = 0, `bullet_en` = 0, `bullet_rgb` = 0.
- On `frame_tick`, each active slot is updated:
  - If y < `SPEED`, the slot goes inactive (off the top edge) and x/y hold their values.
  - Otherwise y is reduced by `SPEED`.
- A spawn occurs on `frame_tick` when all of the following hold: `fire` = 1, cooldown = 0, at least one slot is free, and `p_y` >= `BH`.
  - The target is the lowest-index free slot, using the mask as registered before this cycle.
  - The slot is set to x = `p_x + MUZZLE_DX` (10-bit wrap) and y = `p_y - BH`. It does not move on the same tick.
  - Cooldown loads `COOLDOWN` and `fire_ack` pulses.
- Otherwise, on `frame_tick`, a nonzero cooldown decrements by 1. Cooldown never goes below 0.
- Fire while the pool is full, or while cooldown is nonzero, is dropped. There is no queueing.
- `hit_valid` may arrive in any cycle. It clears `active[hit_idx]`.
  - It has no effect if that slot is already inactive or if `hit_idx` >= `NUM_BULLETS`.
  - A hit on a slot that is moving this cycle wins: the slot goes inactive.
  - A hit naming the slot chosen for spawn has no effect, because that slot was inactive; the spawn proceeds.
- Pixel test per slot: active AND `pix_x` in [x, x+BW) AND `pix_y` in [y, y+BH). Comparisons use 11-bit sums so that x+BW and y+BH do not wrap. `bullet_en` is the OR across slots.

## Timing
- State updates take effect one cycle after `frame_tick` or `hit_valid`.
- `fire_ack` is high the cycle after the accepting `frame_tick`.
- `bullet_en` and `bullet_rgb` lag `pix_x`/`pix_y` by exactly 1 cycle; the mixer compensates.
- Reset is asynchronous. Asserting it mid-frame clears all slots immediately. The first spawn after release needs the next `frame_tick`.

## Structure
- Shared package `bullet_pkg`: `SCREEN_W` = 640, `SCREEN_H` = 480, `COORD_W` = 10, an RGB444 typedef, and the default colours.
- Sub-module `bullet_slot`: one instance per slot, holding active/x/y, the move, clear and spawn logic, and the pixel hit compare.
- The top level holds the free-slot priority encoder, the cooldown counter, the OR-reduce and the output registers.

## Test plan
- Reset, then `fire` = 1 with `p_x` = 100, `p_y` = 400 on a tick -> slot 0 x=123, y=384, `fire_ack` pulses once. The next tick -> y=382.
- Hold `fire` = 1 with `COOLDOWN` = 8 -> spawns on ticks 0, 9, 18 and 27; a fifth attempt with 4 slots full is dropped and no ack is issued.
- Slot at y=1 with `SPEED` = 2, then a tick -> slot inactive and its position frozen. The freed slot index is reused by the next spawn.
- `hit_valid`, `hit_idx` = 1 on the same cycle as `frame_tick` with slots 0-1 active -> slot 1 cleared, slot 0 moved. `hit_idx` = 7 -> no change.
- Bullet at (123,384): pixels (123,384), (126,399) -> `bullet_en` = 1 and `bullet_rgb` = 12'h00F one cycle later. Pixels (127,384) and (123,400) -> `bullet_en` = 0.
- Assert `rst` mid-frame with 3 active slots -> `active` = 0 and `bullet_en` = 0 immediately. `fire` with `p_y` = 10 (< `BH`) -> rejected.
